// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADJ_THRESH  = 4'd5;
    localparam logic [3:0]  ADJ_ADD     = 4'd3;

    // Decimal digits needed for 2**bin_w - 1, i.e. ceil(bin_w * log10(2)).
    function automatic int unsigned min_digits(input int unsigned bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One shift-add-3 digit adjuster: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj_digit
);

    always_comb begin
        adj_digit = digit;
        if (digit >= ADJ_THRESH) begin
            adj_digit = digit + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// valid/ready handshake on both sides, optional signed input and overflow flag.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                       clk_pi,
    input  logic                       rst_pi,
    input  logic [BIN_W-1:0]           num_pi,
    input  logic                       in_valid_pi,
    output logic                       in_ready_po,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcdnum_po,
    output logic                       neg_po,
    output logic                       overflow_po,
    output logic                       out_valid_po,
    input  logic                       out_ready_pi
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [BCD_W-1:0]   digits_q;
    logic [BCD_W-1:0]   digits_adj;
    logic [BIN_W-1:0]   bin_q;
    logic [BIN_W-1:0]   mag;
    logic [CNT_W-1:0]   count;
    logic               neg_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic               in_neg;

    assign in_neg = SIGNED && num_pi[BIN_W-1];
    assign mag    = in_neg ? (~num_pi + 1'b1) : num_pi;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit     (digits_q[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj_digit (digits_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            state       <= ST_IDLE;
            digits_q    <= '0;
            bin_q       <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_pi) begin
                        bin_q    <= mag;
                        neg_q    <= in_neg;
                        digits_q <= '0;
                        ovf_q    <= 1'b0;
                        count    <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The top bit of the adjusted digits falls off the end; any 1 there
                    // means the magnitude needs more digits than are kept.
                    {digits_q, bin_q} <= {digits_adj[BCD_W-2:0], bin_q, 1'b0};
                    ovf_q             <= ovf_q | digits_adj[BCD_W-1];
                    count             <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready_pi) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_po  = (state == ST_IDLE) & ~rst_pi;
    assign bcdnum_po    = digits_q;
    assign neg_po       = neg_q;
    assign overflow_po  = ovf_q;
    assign out_valid_po = out_valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: four parameterisations checked every cycle against an
// arithmetic reference model, plus directed literal checks.
module tb_bin2bcd_seq;

    localparam int NI = 4;
    localparam int BWS [NI] = '{8, 16, 8, 8};
    localparam int DGS [NI] = '{3, 5, 3, 2};
    localparam bit SGS [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] num       [NI];
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic        neg       [NI];
    logic        ovf       [NI];
    logic [19:0] bcd       [NI];
    int          hs_dut    [NI];
    int          hs_mdl    [NI];
    bit          acc       [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    // Reference: magnitude by arithmetic negation, decimal digits by repeated /10.
    function automatic void ref_conv(input int g, input logic [15:0] v,
                                     output logic [19:0] eb, output logic en, output logic eo);
        longint unsigned mag, lim, r;
        int bw;
        bw  = BWS[g];
        mag = 64'(v) & ((64'd1 << bw) - 64'd1);
        en  = SGS[g] && v[bw-1];
        if (en) mag = (64'd1 << bw) - mag;
        lim = 1;
        for (int i = 0; i < DGS[g]; i++) lim = lim * 10;
        eo = (mag >= lim);
        r  = mag % lim;
        eb = '0;
        for (int i = 0; i < DGS[g]; i++) begin
            eb[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int BW = BWS[g];
        localparam int DG = DGS[g];
        logic [BW-1:0]   num_w;
        logic [4*DG-1:0] bcd_w;
        logic            ir_w, ov_w, ng_w, of_w;

        bit          pend = 1'b0;
        int          age  = 0;
        logic [19:0] eb   = '0;
        logic        en   = 1'b0;
        logic        eo   = 1'b0;
        int          n_mdl = 0;
        int          n_dut = 0;

        assign num_w        = num[g][BW-1:0];
        assign bcd[g]       = 20'(bcd_w);
        assign in_ready[g]  = ir_w;
        assign out_valid[g] = ov_w;
        assign neg[g]       = ng_w;
        assign ovf[g]       = of_w;
        assign hs_dut[g]    = n_dut;
        assign hs_mdl[g]    = n_mdl;

        bin2bcd_seq #(.BIN_W(BW), .DIGITS(DG), .SIGNED(SGS[g])) u_dut (
            .clk_pi       (clk),
            .rst_pi       (rst),
            .num_pi       (num_w),
            .in_valid_pi  (in_valid[g]),
            .in_ready_po  (ir_w),
            .bcdnum_po    (bcd_w),
            .neg_po       (ng_w),
            .overflow_po  (of_w),
            .out_valid_po (ov_w),
            .out_ready_pi (out_ready[g])
        );

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                pend <= 1'b0;
                age  <= 0;
            end else begin
                logic [19:0] b;
                logic        n, o;
                if (pend && age >= BW && out_ready[g]) begin
                    pend  <= 1'b0;
                    n_mdl <= n_mdl + 1;
                end else if (pend) begin
                    age <= age + 1;
                end
                if (!pend && in_valid[g]) begin
                    ref_conv(g, num[g], b, n, o);
                    pend <= 1'b1;
                    age  <= 0;
                    eb   <= b;
                    en   <= n;
                    eo   <= o;
                end
            end
        end

        always @(negedge clk) begin
            chk("in_ready", g, 32'(in_ready[g]), 32'(!pend && !rst));
            chk("out_valid", g, 32'(out_valid[g]), 32'(pend && age >= BW));
            if (pend && age >= BW) begin
                chk("bcd", g, 32'(bcd[g]), 32'(eb));
                chk("neg", g, 32'(neg[g]), 32'(en));
                chk("ovf", g, 32'(ovf[g]), 32'(eo));
            end
            if (out_valid[g] && out_ready[g]) n_dut <= n_dut + 1;
        end
    end

    function automatic logic [15:0] pick(input int g);
        logic [31:0] mask;
        mask = (32'd1 << BWS[g]) - 32'd1;
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'(mask);
            2:       return 16'(32'd1 << (BWS[g] - 1));
            default: return 16'($urandom & mask);
        endcase
    endfunction

    // Called and returns just after a rising edge.
    task automatic convert(input int g, input logic [15:0] v, input logic [19:0] xb,
                           input logic xn, input logic xo, input int hold);
        logic [19:0] mb;
        logic        mn, mo;
        int          k;
        bit          ok;
        ref_conv(g, v, mb, mn, mo);
        chk("model_bcd", g, 32'(mb), 32'(xb));
        chk("model_neg", g, 32'(mn), 32'(xn));
        chk("model_ovf", g, 32'(mo), 32'(xo));
        out_ready[g] = (hold == 0);
        num[g]       = v;
        in_valid[g]  = 1'b1;
        ok = 1'b0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready[g]) begin ok = 1'b1; break; end
        end
        chk("accept", g, 32'(ok), 32'd1);
        @(posedge clk);
        #1 in_valid[g] = 1'b0;
        ok = 1'b0;
        for (k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (out_valid[g]) begin ok = 1'b1; break; end
        end
        chk("result_seen", g, 32'(ok), 32'd1);
        chk("latency", g, 32'(k - 1), 32'(BWS[g]));
        chk("lit_bcd", g, 32'(bcd[g]), 32'(xb));
        chk("lit_neg", g, 32'(neg[g]), 32'(xn));
        chk("lit_ovf", g, 32'(ovf[g]), 32'(xo));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", g, 32'(out_valid[g]), 32'd1);
                chk("hold_bcd", g, 32'(bcd[g]), 32'(xb));
                chk("hold_ready", g, 32'(in_ready[g]), 32'd0);
            end
            @(posedge clk);
            #1 out_ready[g] = 1'b1;
        end
        @(posedge clk);
        #1 chk("valid_drop", g, 32'(out_valid[g]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        bit ok;
        for (int g = 0; g < NI; g++) begin
            num[g] = '0; in_valid[g] = 1'b0; out_ready[g] = 1'b1;
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rst_bcd", g, 32'(bcd[g]), 32'd0);
            chk("rst_valid", g, 32'(out_valid[g]), 32'd0);
            chk("rst_ready", g, 32'(in_ready[g]), 32'd0);
            chk("rst_ovf", g, 32'(ovf[g]), 32'd0);
        end
        rst = 1'b0;

        convert(0, 16'd255,   20'h00255, 1'b0, 1'b0, 0);
        convert(0, 16'd0,     20'h00000, 1'b0, 1'b0, 0);
        convert(0, 16'd99,    20'h00099, 1'b0, 1'b0, 0);
        convert(1, 16'hFFFF,  20'h65535, 1'b0, 1'b0, 0);
        convert(1, 16'd10000, 20'h10000, 1'b0, 1'b0, 0);
        convert(2, 16'h0080,  20'h00128, 1'b1, 1'b0, 0);
        convert(2, 16'h0000,  20'h00000, 1'b0, 1'b0, 0);
        convert(2, 16'h00FF,  20'h00001, 1'b1, 1'b0, 0);
        convert(2, 16'h007F,  20'h00127, 1'b0, 1'b0, 0);
        convert(3, 16'd200,   20'h00000, 1'b0, 1'b1, 0);
        convert(3, 16'd99,    20'h00099, 1'b0, 1'b0, 0);
        convert(3, 16'd100,   20'h00000, 1'b0, 1'b1, 0);
        convert(0, 16'd37,    20'h00037, 1'b0, 1'b0, 10);

        // Reset in the middle of a conversion.
        num[0] = 16'd200; in_valid[0] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready[0]) begin ok = 1'b1; break; end
        end
        chk("rst_accept", 0, 32'(ok), 32'd1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("midrst_bcd", 0, 32'(bcd[0]), 32'd0);
        chk("midrst_ready", 0, 32'(in_ready[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (BWS[0] + 4) begin
            @(negedge clk);
            chk("no_valid_after_rst", 0, 32'(out_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        convert(0, 16'd42, 20'h00042, 1'b0, 1'b0, 0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) acc[g] = in_valid[g] && in_ready[g];
            @(posedge clk);
            #1;
            for (int g = 0; g < NI; g++) begin
                out_ready[g] = ($urandom_range(0, 3) != 0);
                if (!in_valid[g] || acc[g]) begin
                    in_valid[g] = ($urandom_range(0, 1) == 1);
                    num[g]      = pick(g);
                end
            end
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("handshake_count", g, 32'(hs_dut[g]), 32'(hs_mdl[g]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
